// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial shifter with a valid/ready word input,
// a bit-rate enable and frame markers on the serial side.
// A new word can be loaded on the edge that consumes the last bit of the
// current one, so back-to-back words stream with no idle bit between them.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             en,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy,
    output logic [15:0]      words_sent
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   shreg_shift_s;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [15:0]        words_q, words_d;
    logic               last_s;
    logic               tx_bit_s;

    // Shift toward the transmitted end and pick the bit currently on the line.
    always_comb begin
        shreg_shift_s = shreg_q;
        tx_bit_s      = 1'b0;
        if (MSB_FIRST) begin
            shreg_shift_s = {shreg_q[WIDTH-2:0], 1'b0};
            tx_bit_s      = shreg_q[WIDTH-1];
        end else begin
            shreg_shift_s = {1'b0, shreg_q[WIDTH-1:1]};
            tx_bit_s      = shreg_q[0];
        end
    end

    // Handshake and serial-side outputs, decoded from state, counter and en.
    always_comb begin
        last_s      = (cnt_q == LAST_CNT);
        din_ready   = 1'b0;
        sout        = 1'b0;
        sout_valid  = 1'b0;
        busy        = 1'b0;
        if (state_q == SHIFT) begin
            busy       = 1'b1;
            sout       = tx_bit_s;
            sout_valid = en;
            din_ready  = en & last_s;
        end else begin
            din_ready  = 1'b1;
        end
        frame_start = sout_valid & (cnt_q == {CW{1'b0}});
        frame_end   = sout_valid & last_s;
        words_sent  = words_q;
    end

    // Next-state logic: load on transfer, shift on en, wrap to next word or idle.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    shreg_d = din;
                    cnt_d   = {CW{1'b0}};
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (!en) begin
                    state_d = SHIFT;
                end else if (!last_s) begin
                    shreg_d = shreg_shift_s;
                    cnt_d   = cnt_q + CW'(1);
                end else begin
                    words_d = words_q + 16'd1;
                    if (din_valid) begin
                        shreg_d = din;
                        cnt_d   = {CW{1'b0}};
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; synchronous reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            words_q <= 16'd0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer: directed vector table, LSB-first sequence,
// randomized run against a bit-queue reference model, and a WIDTH=2
// counter wrap run on a faster clock.
module tb_bit_serializer;

    typedef bit bitq_t[$];

    typedef struct {
        logic        r;
        logic        dv;
        logic [7:0]  d;
        logic        e;
        logic        c;
        logic        rdy;
        logic        so;
        logic        sv;
        logic        fs;
        logic        fe;
        logic        bz;
        logic [15:0] ws;
    } vec_t;

    logic clk  = 1'b0;
    logic clk2 = 1'b0;
    logic rst  = 1'b1;

    // instance a: WIDTH=8, MSB first
    logic [7:0]  din_a = 8'h00;
    logic        dv_a  = 1'b0, en_a = 1'b0;
    logic        rdy_a, so_a, sv_a, fs_a, fe_a, bz_a;
    logic [15:0] ws_a;
    // instance b: WIDTH=8, LSB first
    logic [7:0]  din_b = 8'h00;
    logic        dv_b  = 1'b0, en_b = 1'b0;
    logic        rdy_b, so_b, sv_b, fs_b, fe_b, bz_b;
    logic [15:0] ws_b;
    // instance c: WIDTH=2, MSB first, fast clock
    logic [1:0]  din_c = 2'b00;
    logic        dv_c  = 1'b0, en_c = 1'b0;
    logic        rdy_c, so_c, sv_c, fs_c, fe_c, bz_c;
    logic [15:0] ws_c;

    int n_chk = 0;
    int n_err = 0;

    vec_t  vecs[$];
    bitq_t q_a, q_b;
    logic [15:0] w_a, w_b;

    always #5 clk  = ~clk;
    always #1 clk2 = ~clk2;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(dv_a), .din_ready(rdy_a),
        .en(en_a), .sout(so_a), .sout_valid(sv_a), .frame_start(fs_a),
        .frame_end(fe_a), .busy(bz_a), .words_sent(ws_a));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(dv_b), .din_ready(rdy_b),
        .en(en_b), .sout(so_b), .sout_valid(sv_b), .frame_start(fs_b),
        .frame_end(fe_b), .busy(bz_b), .words_sent(ws_b));

    bit_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) u_c (
        .clk(clk2), .rst(rst), .din(din_c), .din_valid(dv_c), .din_ready(rdy_c),
        .en(en_c), .sout(so_c), .sout_valid(sv_c), .frame_start(fs_c),
        .frame_end(fe_c), .busy(bz_c), .words_sent(ws_c));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic dv, input logic [7:0] d, input logic e,
                       input logic c, input logic rdy, input logic so, input logic sv,
                       input logic fs, input logic fe, input logic bz, input logic [15:0] ws);
        vec_t v;
        v.r = r; v.dv = dv; v.d = d; v.e = e; v.c = c;
        v.rdy = rdy; v.so = so; v.sv = sv; v.fs = fs; v.fe = fe; v.bz = bz; v.ws = ws;
        vecs.push_back(v);
    endtask

    // Reference: the queue holds the bits still to be sent, front = bit on the line.
    task automatic check_model(input string tag, input bitq_t q, input logic [15:0] w,
                               input logic e, input logic rdy, input logic so, input logic sv,
                               input logic fs, input logic fe, input logic bz,
                               input logic [15:0] ws);
        logic busy_m, sout_m, valid_m, ready_m;
        busy_m  = (q.size() != 0);
        sout_m  = busy_m ? q[0] : 1'b0;
        valid_m = busy_m && e;
        ready_m = !busy_m || (e && q.size() == 1);
        chk({tag, "_ready"}, {31'd0, rdy}, {31'd0, ready_m});
        chk({tag, "_sout"},  {31'd0, so},  {31'd0, sout_m});
        chk({tag, "_valid"}, {31'd0, sv},  {31'd0, valid_m});
        chk({tag, "_fstart"}, {31'd0, fs}, {31'd0, (valid_m && q.size() == 8)});
        chk({tag, "_fend"},  {31'd0, fe},  {31'd0, (valid_m && q.size() == 1)});
        chk({tag, "_busy"},  {31'd0, bz},  {31'd0, busy_m});
        chk({tag, "_words"}, {16'd0, ws},  {16'd0, w});
    endtask

    function automatic void model_edge(inout bitq_t q, inout logic [15:0] w, input bit msb,
                                       input logic r, input logic dv, input logic e,
                                       input logic [7:0] d);
        bit acc;
        if (r) begin
            q.delete();
            w = 16'd0;
            return;
        end
        acc = dv && ((q.size() == 0) || (e && q.size() == 1));
        if (q.size() != 0 && e) begin
            void'(q.pop_front());
            if (q.size() == 0) w = w + 16'd1;
        end
        if (acc) begin
            for (int i = 0; i < 8; i++) q.push_back(msb ? d[7-i] : d[i]);
        end
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] x, y;
        int gaps;
        logic exp_bit;

        // ---------------- directed vector table on instance a ----------------
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        // single 0x99 word
        add(1'b0, 1'b1, 8'h99, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        x = 8'h99;
        for (int k = 0; k < 8; k++)
            add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, (k == 7), x[7-k], 1'b1, (k == 0), (k == 7), 1'b1, 16'd0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
        // back-to-back 0xA5 then 0x3C; din changes to 0x3C while not ready
        add(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
        x = 8'hA5;
        for (int k = 0; k < 8; k++)
            add(1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, (k == 7), x[7-k], 1'b1, (k == 0), (k == 7), 1'b1, 16'd1);
        y = 8'h3C;
        for (int k = 0; k < 8; k++)
            add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, (k == 7), y[7-k], 1'b1, (k == 0), (k == 7), 1'b1, 16'd2);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3);
        // 0xF0 with en alternating 0/1
        add(1'b0, 1'b1, 8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3);
        x = 8'hF0;
        for (int j = 0; j < 16; j++) begin
            if (j % 2 == 0)
                add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, x[7-j/2], 1'b0, 1'b0, 1'b0, 1'b1, 16'd3);
            else
                add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, (j == 15), x[7-j/2], 1'b1, (j == 1), (j == 15), 1'b1, 16'd3);
        end
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4);
        // reset after three bits of 0xFF; word offered with rst is refused
        add(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4);
        for (int k = 0; k < 3; k++)
            add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, (k == 0), 1'b0, 1'b1, 16'd4);
        add(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd4);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].r; dv_a = vecs[i].dv; din_a = vecs[i].d; en_a = vecs[i].e;
            @(negedge clk);
            if (vecs[i].c) begin
                chk($sformatf("v%0d_ready", i),  {31'd0, rdy_a}, {31'd0, vecs[i].rdy});
                chk($sformatf("v%0d_sout", i),   {31'd0, so_a},  {31'd0, vecs[i].so});
                chk($sformatf("v%0d_valid", i),  {31'd0, sv_a},  {31'd0, vecs[i].sv});
                chk($sformatf("v%0d_fstart", i), {31'd0, fs_a},  {31'd0, vecs[i].fs});
                chk($sformatf("v%0d_fend", i),   {31'd0, fe_a},  {31'd0, vecs[i].fe});
                chk($sformatf("v%0d_busy", i),   {31'd0, bz_a},  {31'd0, vecs[i].bz});
                chk($sformatf("v%0d_words", i),  {16'd0, ws_a},  {16'd0, vecs[i].ws});
            end
            @(posedge clk); #1;
        end

        // ---------------- LSB-first 0x01 on instance b ----------------
        rst = 1'b1; dv_b = 1'b0; en_b = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; dv_b = 1'b1; din_b = 8'h01;
        @(negedge clk);
        chk("lsb_idle_ready", {31'd0, rdy_b}, 32'd1);
        chk("lsb_idle_busy",  {31'd0, bz_b},  32'd0);
        @(posedge clk); #1;
        dv_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("lsb_bit%0d", k), {31'd0, so_b}, {31'd0, (k == 0)});
            chk($sformatf("lsb_valid%0d", k), {31'd0, sv_b}, 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("lsb_end_busy",  {31'd0, bz_b},  32'd0);
        chk("lsb_end_words", {16'd0, ws_b},  32'd1);
        @(posedge clk); #1;

        // ---------------- randomized run against the reference model ----------------
        q_a.delete(); q_b.delete(); w_a = 16'd0; w_b = 16'd0;
        for (int it = 0; it < 1500; it++) begin
            rst  = (it == 0) || ($urandom_range(0, 99) == 0);
            dv_a = ($urandom_range(0, 9) < 7);
            en_a = ($urandom_range(0, 3) != 0);
            din_a = 8'($urandom);
            dv_b = dv_a; en_b = en_a; din_b = din_a;
            @(negedge clk);
            if (it != 0) begin
                check_model("rnd_a", q_a, w_a, en_a, rdy_a, so_a, sv_a, fs_a, fe_a, bz_a, ws_a);
                check_model("rnd_b", q_b, w_b, en_b, rdy_b, so_b, sv_b, fs_b, fe_b, bz_b, ws_b);
            end
            @(posedge clk);
            model_edge(q_a, w_a, 1'b1, rst, dv_a, en_a, din_a);
            model_edge(q_b, w_b, 1'b0, rst, dv_b, en_b, din_b);
            #1;
        end

        // ---------------- WIDTH=2: 65536 back-to-back words, counter wrap ----------------
        @(negedge clk2);
        rst = 1'b1; dv_c = 1'b0; en_c = 1'b1; din_c = 2'b10;
        repeat (8) @(negedge clk2);
        chk("w2_idle_ready", {31'd0, rdy_c}, 32'd1);
        chk("w2_idle_words", {16'd0, ws_c},  32'd0);
        rst = 1'b0; dv_c = 1'b1;
        gaps = 0;
        for (int i = 0; i < 131072; i++) begin
            @(negedge clk2);
            exp_bit = (i % 2 == 0);
            if (sv_c !== 1'b1 || so_c !== exp_bit || fs_c !== exp_bit || fe_c !== !exp_bit)
                gaps++;
            if (i == 131070) chk("w2_words_ffff", {16'd0, ws_c}, 32'h0000FFFF);
        end
        @(negedge clk2);
        chk("w2_stream_errs", gaps, 32'd0);
        chk("w2_words_wrap", {16'd0, ws_c}, 32'd0);
        chk("w2_still_busy", {31'd0, bz_c}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = transmit bit WIDTH-1 first, 0 = transmit bit 0 first.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 din_valid  input  1  din holds a word offered for transfer.
REQ-007 din_ready  output  1  block accepts din on this edge.
REQ-008 en  input  1  bit-rate enable; one serial bit is consumed per clk with en=1.
REQ-009 sout  output  1  serial data bit, feeds the downstream detector's serial input.
REQ-010 sout_valid  output  1  sout is a live bit this cycle.
REQ-011 frame_start  output  1  current sout is the first bit of a word.
REQ-012 frame_end  output  1  current sout is the last bit of a word.
REQ-013 busy  output  1  a word is being shifted out.
REQ-014 words_sent  output  16  count of completed words, wraps modulo 2^16.

Function
REQ-015 The block SHALL be a two-state FSM: IDLE, SHIFT; internal registers shreg[WIDTH-1:0], bit counter cnt (clog2(WIDTH) bits), words_sent.
REQ-016 Handshake: a word SHALL transfer on a rising edge where din_valid=1 and din_ready=1, and only then.
REQ-017 din_ready SHALL be 1 in IDLE, and in SHIFT only when en=1 and cnt=WIDTH-1; 0 otherwise (combinational from state, cnt, en).
REQ-018 IDLE + transfer: shreg<=din, cnt<=0, state<=SHIFT; IDLE with no transfer: all registers hold.
REQ-019 busy SHALL be 1 exactly when state=SHIFT.
REQ-020 sout SHALL be shreg[WIDTH-1] when MSB_FIRST=1, shreg[0] when MSB_FIRST=0, while in SHIFT; 0 in IDLE.
REQ-021 sout_valid SHALL equal (state=SHIFT) AND en; combinational.
REQ-022 SHIFT with en=0: shreg, cnt, state, words_sent hold; sout holds its value.
REQ-023 SHIFT with en=1 and cnt<WIDTH-1: shreg shifts one place toward the transmitted end (left for MSB_FIRST=1, right otherwise), vacated bit 0; cnt<=cnt+1.
REQ-024 SHIFT with en=1 and cnt=WIDTH-1: words_sent<=words_sent+1; if din_valid=1 then shreg<=din, cnt<=0, stay SHIFT (zero-gap back-to-back); else state<=IDLE.
REQ-025 frame_start SHALL equal sout_valid AND cnt=0; frame_end SHALL equal sout_valid AND cnt=WIDTH-1.
REQ-026 Bit latency: first bit of an accepted word SHALL appear on sout in the cycle following the transfer edge.
REQ-027 words_sent SHALL wrap from 16'hFFFF to 16'h0000 with no flag.
REQ-028 din changes while din_ready=0 SHALL have no effect.

Reset
REQ-029 rst=1 at a rising edge SHALL force state=IDLE, shreg=0, cnt=0, words_sent=0, overriding every other input.
REQ-030 After reset: din_ready=1, sout=0, sout_valid=0, frame_start=0, frame_end=0, busy=0, words_sent=0.
REQ-031 rst asserted mid-word SHALL discard the partial word; no frame_end or words_sent increment for it.
REQ-032 A word offered in the same cycle as rst=1 SHALL NOT be accepted.

Verification
REQ-033 WIDTH=8, MSB_FIRST=1, en=1, din=8'h99 single transfer -> sout 1,0,0,1,1,0,0,1 on 8 consecutive cycles with sout_valid=1, frame_start on bit 1, frame_end on bit 8, then IDLE, words_sent=1.
REQ-034 din_valid held with 8'hA5 then 8'h3C -> 16 contiguous valid bits 10100101 00111100, din_ready=1 only in IDLE start and the 8th-bit cycle, words_sent=2.
REQ-035 en alternating 1/0 with din=8'hF0 -> 8 bits over 16 cycles, sout_valid=0 on every en=0 cycle, sout stable across stalls, bit order unchanged.
REQ-036 rst pulse after 3 bits of 8'hFF -> next cycle sout_valid=0, busy=0, din_ready=1, words_sent=0, no frame_end.
REQ-037 MSB_FIRST=0, din=8'h01 -> bits 1,0,0,0,0,0,0,0.
REQ-038 WIDTH=2, 65536 back-to-back words -> words_sent returns to 16'h0000, no gap bits.
